// File: rtl/aes_pkg.sv
// Shared AES-128 constants: round count, key-schedule rcon values, field polynomial and S-box table.
package aes_pkg;

  typedef logic [127:0] block_t;
  typedef logic [31:0]  word_t;

  localparam int         NR       = 10;
  localparam logic [3:0] LAST_RND = 4'd10;
  localparam logic [8:0] POLY     = 9'h11B;

  localparam logic [7:0] RCON [NR] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8), reducing by the AES field polynomial.
  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return b[7] ? ({b[6:0], 1'b0} ^ POLY[7:0]) : {b[6:0], 1'b0};
  endfunction

endpackage

// File: rtl/key_expand_step.sv
// One AES-128 key-schedule step: derives the next round key from the current one and its rcon.
import aes_pkg::*;

module key_expand_step (
  input  logic [127:0] rk,
  input  logic [7:0]   rcon,
  output logic [127:0] rk_next
);

  word_t w0, w1, w2, w3;
  word_t rot_w3, sub_w3, t;
  word_t w0_next, w1_next, w2_next, w3_next;

  assign w0 = rk[127:96];
  assign w1 = rk[95:64];
  assign w2 = rk[63:32];
  assign w3 = rk[31:0];

  assign rot_w3 = {w3[23:0], w3[31:24]};

  // SubWord: one S-box lookup per byte of the rotated word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_sub
    assign sub_w3[gi*8 +: 8] = SBOX[rot_w3[gi*8 +: 8]];
  end

  assign t       = sub_w3 ^ {rcon, 24'h000000};
  assign w0_next = w0 ^ t;
  assign w1_next = w1 ^ w0_next;
  assign w2_next = w2 ^ w1_next;
  assign w3_next = w3 ^ w2_next;

  assign rk_next = {w0_next, w1_next, w2_next, w3_next};

endmodule

// File: rtl/round_key_add.sv
// AddRoundKey stage with on-the-fly AES-128 key expansion; one round per accepted state, wrapping after round 10.
import aes_pkg::*;

module round_key_add (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load,
  input  logic [127:0] cipher_key,
  input  logic         in_valid,
  input  logic [127:0] in_state,
  output logic         in_ready,
  output logic         out_valid,
  output logic [127:0] out_state,
  output logic [3:0]   out_round,
  output logic         out_last,
  input  logic         out_ready
);

  block_t     key_reg;
  block_t     rk_reg;
  block_t     rk_next;
  logic [3:0] rnd_reg;
  logic       key_ok_reg;
  logic       out_valid_reg;
  block_t     out_state_reg;
  logic [3:0] out_round_reg;
  logic       out_last_reg;
  logic [7:0] rcon_sel;
  logic       xfer;

  assign in_ready = key_ok_reg & ~key_load & (~out_valid_reg | out_ready);
  assign xfer     = in_valid & in_ready;

  // Round 10 has no successor key; the reload path takes over there.
  assign rcon_sel = (rnd_reg < LAST_RND) ? RCON[rnd_reg] : 8'h00;

  key_expand_step u_key_expand_step (
    .rk      (rk_reg),
    .rcon    (rcon_sel),
    .rk_next (rk_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg       <= '0;
      rk_reg        <= '0;
      rnd_reg       <= '0;
      key_ok_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      out_state_reg <= '0;
      out_round_reg <= '0;
      out_last_reg  <= 1'b0;
    end else if (key_load) begin
      key_reg       <= cipher_key;
      rk_reg        <= cipher_key;
      rnd_reg       <= '0;
      key_ok_reg    <= 1'b1;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else if (xfer) begin
      out_state_reg <= in_state ^ rk_reg;
      out_round_reg <= rnd_reg;
      out_last_reg  <= (rnd_reg == LAST_RND);
      out_valid_reg <= 1'b1;
      if (rnd_reg == LAST_RND) begin
        rk_reg  <= key_reg;
        rnd_reg <= '0;
      end else begin
        rk_reg  <= rk_next;
        rnd_reg <= rnd_reg + 4'd1;
      end
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_state = out_state_reg;
  assign out_round = out_round_reg;
  assign out_last  = out_last_reg;

endmodule

// File: tb/tb_round_key_add.sv
// Directed bench for round_key_add: scoreboard of expected outputs checked against an independent GF(2^8) key-schedule model.
module tb_round_key_add;

  localparam logic [127:0] KEY    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         key_load = 1'b0;
  logic [127:0] cipher_key = '0;
  logic         in_valid = 1'b0;
  logic [127:0] in_state = '0;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] out_state;
  logic [3:0]   out_round;
  logic         out_last;
  logic         out_ready = 1'b0;

  typedef struct {
    logic [127:0] st;
    logic [3:0]   rnd;
    logic         last;
  } exp_t;

  exp_t         q[$];
  logic [127:0] rk_model [11];
  logic [7:0]   sb_model [256];
  int           model_rnd = 0;
  int           tests = 0;
  int           fails = 0;

  round_key_add dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_load   (key_load),
    .cipher_key (cipher_key),
    .in_valid   (in_valid),
    .in_state   (in_state),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_state  (out_state),
    .out_round  (out_round),
    .out_last   (out_last),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gf_mul(inv, x);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] expand_model(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w3 = rk[31:0];
    logic [31:0] t, a, b, c, d;
    t = {sb_model[w3[23:16]], sb_model[w3[15:8]], sb_model[w3[7:0]], sb_model[w3[31:24]]} ^ {rc, 24'h0};
    a = rk[127:96] ^ t;
    b = rk[95:64] ^ a;
    c = rk[63:32] ^ b;
    d = rk[31:0] ^ c;
    return {a, b, c, d};
  endfunction

  // One directed cycle: drive just after the edge, push the expected output if a transfer will happen.
  task automatic step(input logic v, input logic [127:0] s, input logic kl, input logic ordy);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid   = v;
    in_state   = s;
    key_load   = kl;
    out_ready  = ordy;
    cipher_key = KEY;
    #1;
    if (kl) begin
      model_rnd = 0;
    end else if (v && in_ready) begin
      e.st   = s ^ rk_model[model_rnd];
      e.rnd  = 4'(model_rnd);
      e.last = (model_rnd == 10);
      q.push_back(e);
      model_rnd = (model_rnd == 10) ? 0 : model_rnd + 1;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && q.size() > 0; n++) step(1'b0, '0, 1'b0, 1'b1);
    chk("drain_empty", 128'(q.size()), 128'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_output", 128'(out_valid), 128'd0);
      end else begin
        e = q.pop_front();
        $display("[TB] out round %0d last %0d state %h", out_round, out_last, out_state);
        chk("out_state", out_state, e.st);
        chk("out_round", 128'(out_round), 128'(e.rnd));
        chk("out_last", 128'(out_last), 128'(e.last));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rc;
    for (int i = 0; i < 256; i++) sb_model[i] = sbox_calc(8'(i));
    rk_model[0] = KEY;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      rk_model[r] = expand_model(rk_model[r-1], rc);
      rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
    end
    // Published FIPS-197 round keys pin rounds 0, 1 and 10 independently of the model.
    rk_model[0]  = KEY;
    rk_model[1]  = RK1;
    rk_model[10] = RK10;

    // Reset state
    #3 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_out_state", out_state, 128'd0);
    chk("rst_out_round", 128'(out_round), 128'd0);
    chk("rst_out_last", 128'(out_last), 128'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b1, '0, 1'b0, 1'b1);
    chk("in_ready_before_key", 128'(in_ready), 128'd0);

    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("in_ready_after_key", 128'(in_ready), 128'd1);

    // Twelve zero states back-to-back: rounds 0..10 then wrap to round 0
    for (int i = 0; i < 12; i++) begin
      step(1'b1, '0, 1'b0, 1'b1);
      chk("burst_in_ready", 128'(in_ready), 128'd1);
      if (i > 0) chk("no_bubble", 128'(out_valid), 128'd1);
    end
    drain();

    // Back-pressure: output held stable for five cycles
    step(1'b1, 128'h00112233445566778899aabbccddeeff, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 128'hfedcba98765432100123456789abcdef, 1'b0, 1'b0);
      chk("hold_in_ready", 128'(in_ready), 128'd0);
      chk("hold_valid", 128'(out_valid), 128'd1);
      if (q.size() > 0) begin
        chk("hold_state", out_state, q[0].st);
        chk("hold_round", 128'(out_round), 128'(q[0].rnd));
      end
    end
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("hold_released", 128'(out_valid), 128'd0);
    chk("hold_one_accepted", 128'(q.size()), 128'd0);

    // key_load wins over a transfer offered at round 4
    while (model_rnd != 4) step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1);
    step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1);
    chk("kl_in_ready", 128'(in_ready), 128'd0);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("kl_abort_valid", 128'(out_valid), 128'd0);
    step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1);
    drain();

    // Reset asserted mid-sequence
    for (int i = 0; i < 3; i++) step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    q.delete();
    model_rnd = 0;
    chk("mid_rst_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_state", out_state, 128'd0);
    chk("mid_rst_round", 128'(out_round), 128'd0);
    chk("mid_rst_last", 128'(out_last), 128'd0);
    chk("mid_rst_in_ready", 128'(in_ready), 128'd0);
    step(1'b1, '0, 1'b0, 1'b1);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, '0, 1'b0, 1'b1);
      chk("post_rst_in_ready", 128'(in_ready), 128'd0);
      chk("post_rst_valid", 128'(out_valid), 128'd0);
    end
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, '0, 1'b0, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/round_key_add.md
ROUND_KEY_ADD -- requirements
Module: round_key_add

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; it has no parameters (AES-128 fixed).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 key_load  input  1  single-cycle pulse; captures cipher_key as the round-0 key.
REQ-005 cipher_key  input  128  AES-128 key; bits [127:120] are key byte 0, and word w0 = bits [127:96].
REQ-006 in_valid  input  1  in_state carries a state (the mix-column stage result, or the raw block for round 0).
REQ-007 in_state  input  128  state, byte-ordered as the mix-column stage output; bits [127:120] = byte 0.
REQ-008 in_ready  output  1  the block accepts in_state this cycle.
REQ-009 out_valid  output  1  out_state is valid.
REQ-010 out_state  output  128  in_state XOR the current round key.
REQ-011 out_round  output  4  round index 0..10 of the key applied to out_state.
REQ-012 out_last  output  1  high with out_valid when out_round = 10.
REQ-013 out_ready  input  1  the downstream stage accepts out_state.

Function
REQ-014 The block SHALL hold the current round key rk[127:0], a round counter rnd (0..10) and a copy of cipher_key.
REQ-015 key_load SHALL set the key copy and rk to cipher_key, set rnd = 0, set key_ok = 1, and clear out_valid in the next cycle (abort).
REQ-016 in_ready SHALL equal key_ok AND NOT key_load AND (NOT out_valid OR out_ready).
REQ-017 A transfer SHALL occur when in_valid AND in_ready; in the next cycle, out_state = in_state XOR rk, out_round = rnd, and out_valid = 1 (latency 1 cycle).
REQ-018 On a transfer with rnd < 10, rk SHALL become expand(rk, rcon[rnd]) and rnd SHALL become rnd+1.
REQ-019 On a transfer with rnd = 10, rk SHALL reload from the key copy and rnd SHALL wrap to 0, so the next block needs no key_load.
REQ-020 expand SHALL follow FIPS-197: t = SubWord(RotWord(w3)) XOR {rcon,24'h0}; w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
REQ-021 The rcon sequence SHALL be 01,02,04,08,10,20,40,80,1B,36.
REQ-022 out_valid SHALL clear when out_ready = 1 and no transfer occurs; out_* SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-023 A simultaneous output accept and new transfer SHALL deliver back-to-back outputs with no bubble.
REQ-024 key_load SHALL take priority over a transfer in the same cycle; that input is not accepted.
REQ-025 out_state and out_round SHALL be don't-care when out_valid = 0.

Reset
REQ-026 Reset SHALL clear rk, the key copy, rnd, out_state, out_round, out_last, out_valid and key_ok to 0; in_ready is therefore 0 until the first key_load.
REQ-027 Reset asserted mid-block SHALL discard all state; no output SHALL be produced until key_load is followed by a transfer.

Structure
REQ-028 The shared package aes_pkg SHALL hold the rcon table, NR = 10, and the field polynomial 9'h11B.
REQ-029 One sub-module, key_expand_step (combinational: rk and rcon in, next rk out), SHALL contain the four S-box lookups for SubWord.
REQ-030 All registers SHALL sit in round_key_add; the S-box SHALL be a combinational table.

Verification
REQ-031 Load key 2b7e151628aed2a6abf7158809cf4f3c, send in_state = 0 with out_ready = 1 -> out_state = 2b7e151628aed2a6abf7158809cf4f3c, out_round = 0.
REQ-032 Same key, eleven zero states back-to-back -> round 1 output a0fafe1788542cb123a339392a6c7605; round 10 output d014f9a8c9ee2589e13f0cc8b6630ca6 with out_last = 1; no bubbles.
REQ-033 After the test in REQ-032, a twelfth zero state -> out_round = 0 and output equals the cipher key (wrap-around).
REQ-034 Hold out_ready = 0 for 5 cycles with out_valid = 1 -> out_* stable and in_ready = 0; raise out_ready -> one output accepted.
REQ-035 Pulse key_load together with in_valid at round 4 -> input not accepted, out_valid = 0 next cycle, next accepted state tagged round 0.
REQ-036 Assert rst_n = 0 mid-sequence -> all outputs 0 immediately; in_ready stays 0 until key_load.
